// File: rtl/fetch_pkg.sv
// Shared constants and PC helpers for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN       = 32;
    localparam int XLEN_WIDTH = 5;

    localparam logic true  = 1'b1;
    localparam logic false = 1'b0;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Sequential PC step; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] addr);
        return addr + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through instruction buffer with synchronous clear and occupancy count.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // Empty buffer presents zero rather than a stale entry.
    assign head_data = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
    assign count     = count_reg;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC ownership, credit-limited memory requests,
// buffered delivery to decode, and redirect with stale-response discard.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_jump,
    input  logic [XLEN-1:0] pc_jump_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic            fetch_misaligned
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] head_pc_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   drop_reg;
    logic            misaligned_reg;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic            grant;
    logic            push;
    logic            pop;

    // Every granted request owns a buffer slot until it returns or is popped.
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, count};
    assign imem_req    = rst && !pc_jump && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_addr   = fetch_pc_reg;

    assign grant = imem_req && imem_gnt;
    assign push  = imem_rvalid && (drop_reg == '0) && !pc_jump;
    assign pop   = inst_valid && inst_ready && !pc_jump;

    assign inst_valid       = (count != '0);
    assign pc               = head_pc_reg;
    assign fetch_misaligned = misaligned_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_reg    <= RESET_PC;
            head_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            misaligned_reg  <= 1'b0;
        end else begin
            misaligned_reg  <= pc_jump && (pc_jump_addr[1:0] != 2'b00);
            outstanding_reg <= outstanding_reg + CW'(grant) - CW'(imem_rvalid);
            if (pc_jump) begin
                fetch_pc_reg <= word_align(pc_jump_addr);
                head_pc_reg  <= word_align(pc_jump_addr);
                // drop is a subset of outstanding: everything still in flight is now stale.
                drop_reg     <= outstanding_reg - CW'(imem_rvalid);
            end else begin
                if (grant) begin
                    fetch_pc_reg <= pc_step(fetch_pc_reg);
                end
                if (pop) begin
                    head_pc_reg <= pc_step(head_pc_reg);
                end
                if (imem_rvalid && (drop_reg != '0)) begin
                    drop_reg <= drop_reg - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (pc_jump),
        .push      (push),
        .push_data (imem_rdata),
        .pop       (pop),
        .head_data (inst),
        .count     (count)
    );

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: in-order memory model returning address-as-data,
// plus a stream model of which PC must be delivered next.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_jump;
    logic [31:0] pc_jump_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fetch_misaligned;

    fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_jump          (pc_jump),
        .pc_jump_addr     (pc_jump_addr),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst             (inst),
        .pc               (pc),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] dq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          n_grants = 0;
    int          n_mis    = 0;
    logic [31:0] exp_pc, exp_req_addr;
    logic        exp_mis, after_jump;
    logic        cap_valid, cap_req, coincide;
    logic [31:0] cap_pc, cap_inst, cap_req_addr;
    int          cap_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_pc       = 32'h0;
        exp_req_addr = 32'h0;
        exp_mis      = 1'b0;
        after_jump   = 1'b0;
        cap_valid    = 1'b1;
        cap_req      = 1'b1;
        cyc          = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(imem_req), 32'd0);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_pc"},    pc, 32'h0);
        chk({tag, "_inst"},  inst, 32'h0);
        chk({tag, "_mis"},   32'(fetch_misaligned), 32'd0);
    endtask

    task automatic check_outputs();
        chk("misaligned", 32'(fetch_misaligned), 32'(exp_mis));
        if (fetch_misaligned) n_mis++;
        if (after_jump) chk("valid_after_jump", 32'(inst_valid), 32'd0);
        if (inst_valid) begin
            chk("pc", pc, exp_pc);
            chk("inst", inst, exp_pc);
            if (cap_valid) begin
                cap_valid = 1'b0;
                cap_pc    = pc;
                cap_inst  = inst;
                cap_cyc   = cyc;
            end
        end
    endtask

    // One clock: caller sets pc_jump/inst_ready at the negedge; memory answers here.
    task automatic step();
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0].addr;
        end
        #1;
        check_outputs();
        if (imem_req && imem_gnt) begin
            chk("req_addr", imem_addr, exp_req_addr);
            chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
            if (cap_req) begin
                cap_req      = 1'b0;
                cap_req_addr = imem_addr;
            end
            mq.push_back('{addr: imem_addr, due: cyc + 1 + lat});
            exp_req_addr = exp_req_addr + 32'd4;
            n_grants++;
        end
        if (imem_rvalid) void'(mq.pop_front());
        if (pc_jump) begin
            chk("req_on_jump", 32'(imem_req), 32'd0);
            coincide     = imem_rvalid && inst_valid && inst_ready;
            exp_pc       = {pc_jump_addr[31:2], 2'b00};
            exp_req_addr = {pc_jump_addr[31:2], 2'b00};
            exp_mis      = (pc_jump_addr[1:0] != 2'b00);
            after_jump   = 1'b1;
            cap_valid    = 1'b1;
            cap_req      = 1'b1;
        end else begin
            exp_mis    = 1'b0;
            after_jump = 1'b0;
            if (inst_valid && inst_ready) begin
                dq.push_back(pc);
                exp_pc = exp_pc + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic jump(input logic [31:0] target);
        pc_jump      = 1'b1;
        pc_jump_addr = target;
        step();
        pc_jump      = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        pc_jump      = 1'b0;
        pc_jump_addr = 32'h0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        inst_ready   = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        #1;
        chk("req_after_release", 32'(imem_req), 32'd1);

        // Streaming with 1-cycle memory: one instruction per cycle from cycle 2.
        dq.delete();
        repeat (12) step();
        chk("t1_first_cyc", 32'(cap_cyc), 32'd2);
        chk("t1_first_pc", cap_pc, 32'h0);
        chk("t1_count", 32'(dq.size()), 32'd10);
        if (dq.size() == 10) chk("t1_last_pc", dq[9], 32'h24);

        // Fill the buffer with latency 3, then reset mid-operation.
        inst_ready = 1'b0;
        lat        = 3;
        repeat (5) step();
        rst = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Stall from reset: credit limit allows exactly four grants.
        lat      = 1;
        n_grants = 0;
        repeat (10) step();
        chk("stall_grants", 32'(n_grants), 32'd4);
        chk("stall_first_req", cap_req_addr, 32'h0);
        #1;
        chk("stall_req_low", 32'(imem_req), 32'd0);
        @(negedge clk);
        inst_ready = 1'b1;
        dq.delete();
        repeat (10) step();
        if (dq.size() >= 4) begin
            chk("stall_out0", dq[0], 32'h0);
            chk("stall_out1", dq[1], 32'h4);
            chk("stall_out2", dq[2], 32'h8);
            chk("stall_out3", dq[3], 32'hC);
        end else begin
            chk("stall_out_count", 32'(dq.size()), 32'd4);
        end

        // Redirect with latency 3 and requests in flight.
        lat = 3;
        repeat (6) step();
        chk("t3_inflight", 32'(mq.size() >= 2), 32'd1);
        jump(32'h0000_0100);
        repeat (15) step();
        chk("t3_first_pc", cap_pc, 32'h100);
        chk("t3_first_inst", cap_inst, 32'h100);

        // Redirect coinciding with a response and a pop.
        lat = 1;
        repeat (8) step();
        jump(32'h0000_0040);
        chk("t4_coincide", 32'(coincide), 32'd1);
        dq.delete();
        repeat (10) step();
        chk("t4_first_pc", cap_pc, 32'h40);
        if (dq.size() >= 2) chk("t4_second", dq[1], 32'h44);
        else chk("t4_count", 32'(dq.size()), 32'd2);

        // Misaligned target.
        n_mis = 0;
        jump(32'h0000_0203);
        repeat (10) step();
        chk("t5_mis_pulses", 32'(n_mis), 32'd1);
        chk("t5_first_req", cap_req_addr, 32'h200);
        chk("t5_first_pc", cap_pc, 32'h200);

        // Wrap at the top of the address space.
        jump(32'hFFFF_FFF8);
        dq.delete();
        repeat (8) step();
        if (dq.size() >= 3) begin
            chk("wrap_pc1", dq[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", dq[2], 32'h0);
        end else begin
            chk("wrap_count", 32'(dq.size()), 32'd3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
